// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state type, column count and the GF(2^8) helpers
// used by the column mixer. All products are built from xtime and XOR only.
package aes_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mc_state_e;

   localparam int NCOLS = 4;
   localparam logic [7:0] GF_POLY = 8'h1B;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
   endfunction

   function automatic logic [7:0] gmul2(input logic [7:0] b);
      return xtime(b);
   endfunction

   function automatic logic [7:0] gmul3(input logic [7:0] b);
      return xtime(b) ^ b;
   endfunction

   // Inverse coefficients decomposed into the 8/4/2/1 powers of x.
   function automatic logic [7:0] gmul9(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] gmulb(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] gmuld(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] gmule(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

endpackage

// File: rtl/mixcolumn_col.sv
// Purely combinational (Inv)MixColumns of one 32-bit column; byte 0 is col[31:24].
module mixcolumn_col
   import aes_pkg::*;
(
   input  logic [31:0] col,
   input  logic        inv,
   output logic [31:0] y
);

   logic [7:0] s [4];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_row
         assign s[gi] = col[31-8*gi -: 8];
      end
      // Row r combines s_r..s_{r+3} with the rotated coefficient set.
      for (gi = 0; gi < 4; gi++) begin : g_mix
         assign y[31-8*gi -: 8] = inv
            ? (gmule(s[gi]) ^ gmulb(s[(gi+1)%4]) ^ gmuld(s[(gi+2)%4]) ^ gmul9(s[(gi+3)%4]))
            : (gmul2(s[gi]) ^ gmul3(s[(gi+1)%4]) ^ s[(gi+2)%4] ^ s[(gi+3)%4]);
      end
   endgenerate

endmodule

// File: rtl/mixcolumns_seq.sv
// Sequential AES (Inv)MixColumns: mixes COLS_PER_CYCLE columns per busy cycle
// in place in a working register, then presents the state with a valid/ready hold.
module mixcolumns_seq
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic         in_inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state
);

   localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

   mc_state_e             state_q, state_d;
   logic [1:0]            col_idx_q, col_idx_d;
   logic                  inv_q, inv_d;
   logic [3:0][31:0]      work_q, work_d;
   logic [127:0]          out_state_q, out_state_d;
   logic                  out_valid_q, out_valid_d;
   logic                  last_col;

   logic [31:0] mix_in  [COLS_PER_CYCLE];
   logic [31:0] mix_out [COLS_PER_CYCLE];
   logic [1:0]  col_sel [COLS_PER_CYCLE];

   // Packed element 3 holds bits [127:96], i.e. column 0.
   genvar gi;
   generate
      for (gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
         assign col_sel[gi] = 2'(NCOLS - 1 - gi) - col_idx_q;
         assign mix_in[gi]  = work_q[col_sel[gi]];
         mixcolumn_col u_col (
            .col (mix_in[gi]),
            .inv (inv_q),
            .y   (mix_out[gi])
         );
      end
   endgenerate

   assign last_col  = (int'(col_idx_q) + COLS_PER_CYCLE) >= NCOLS;
   assign in_ready  = (state_q == ST_IDLE) && !reset;
   assign out_valid = out_valid_q;
   assign out_state = out_state_q;

   always_comb begin
      state_d     = state_q;
      col_idx_d   = col_idx_q;
      inv_d       = inv_q;
      work_d      = work_q;
      out_state_d = out_state_q;
      out_valid_d = out_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               work_d    = in_state;
               inv_d     = in_inv;
               col_idx_d = 2'd0;
               state_d   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            for (int i = 0; i < COLS_PER_CYCLE; i++) begin
               work_d[col_sel[i]] = mix_out[i];
            end
            col_idx_d = col_idx_q + COL_STEP;
            if (last_col) begin
               state_d     = ST_DONE;
               out_valid_d = 1'b1;
               out_state_d = work_d;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         col_idx_q   <= 2'd0;
         inv_q       <= 1'b0;
         work_q      <= '0;
         out_state_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_idx_q   <= col_idx_d;
         inv_q       <= inv_d;
         work_q      <= work_d;
         out_state_q <= out_state_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_mixcolumns_seq.sv
// Directed bench: three instances (1, 2 and 4 columns per cycle) driven with
// FIPS-197 style vectors, backpressure, mid-operation reset and mode toggling.
module tb_mixcolumns_seq;

   logic         clk = 1'b0;
   logic         reset     [3];
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic [127:0] in_state  [3];
   logic         in_inv    [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic [127:0] out_state [3];

   int checks = 0;
   int failures = 0;

   localparam logic [127:0] V_PLAIN = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
   localparam logic [127:0] V_MIXED = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
   localparam logic [127:0] V_FIXIN = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] V_FIXMX = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_dut
         mixcolumns_seq #(.COLS_PER_CYCLE(gi == 0 ? 1 : (gi == 1 ? 2 : 4))) u_dut (
            .clk       (clk),
            .reset     (reset[gi]),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .in_state  (in_state[gi]),
            .in_inv    (in_inv[gi]),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready[gi]),
            .out_state (out_state[gi])
         );
      end
   endgenerate

   task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept a state, confirm the exact latency, optionally hold in DONE, then release.
   task automatic run_vec(input int idx, input string tag, input logic [127:0] st,
                          input logic inv, input logic [127:0] exp, input int lat,
                          input int hold);
      chk_eq({tag, " in_ready before accept"}, 128'(in_ready[idx]), 128'd1);
      in_valid[idx] = 1'b1;
      in_state[idx] = st;
      in_inv[idx]   = inv;
      tick();
      // Keep junk on the inputs: they must be ignored outside IDLE.
      in_state[idx] = {$urandom, $urandom, $urandom, $urandom};
      in_inv[idx]   = ~inv;
      out_ready[idx] = 1'b1;
      for (int k = 1; k <= lat; k++) begin
         if (k == lat) out_ready[idx] = 1'b0;
         tick();
         chk_eq($sformatf("%s out_valid edge %0d", tag, k), 128'(out_valid[idx]),
                128'(k == lat));
      end
      chk_eq({tag, " out_state"}, out_state[idx], exp);
      for (int k = 0; k < hold; k++) begin
         tick();
         chk_eq($sformatf("%s hold %0d out_valid", tag, k), 128'(out_valid[idx]), 128'd1);
         chk_eq($sformatf("%s hold %0d out_state", tag, k), out_state[idx], exp);
         chk_eq($sformatf("%s hold %0d in_ready", tag, k), 128'(in_ready[idx]), 128'd0);
      end
      out_ready[idx] = 1'b1;
      tick();
      in_valid[idx]  = 1'b0;
      out_ready[idx] = 1'b0;
      chk_eq({tag, " released out_valid"}, 128'(out_valid[idx]), 128'd0);
      chk_eq({tag, " released in_ready (no accept on release)"}, 128'(in_ready[idx]), 128'd1);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         reset[i] = 1'b1;
         in_valid[i] = 1'b0;
         in_state[i] = '0;
         in_inv[i] = 1'b0;
         out_ready[i] = 1'b0;
      end
      tick();
      for (int i = 0; i < 3; i++)
         chk_eq($sformatf("dut%0d in_ready during reset", i), 128'(in_ready[i]), 128'd0);
      tick();
      for (int i = 0; i < 3; i++) reset[i] = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk_eq($sformatf("dut%0d reset out_valid", i), 128'(out_valid[i]), 128'd0);
         chk_eq($sformatf("dut%0d reset out_state", i), out_state[i], 128'd0);
         chk_eq($sformatf("dut%0d reset in_ready", i), 128'(in_ready[i]), 128'd1);
      end

      run_vec(0, "c1 fwd fips", V_PLAIN, 1'b0, V_MIXED, 4, 0);
      run_vec(1, "c2 inv fips", V_MIXED, 1'b1, V_PLAIN, 2, 0);
      run_vec(2, "c4 fwd fixed", V_FIXIN, 1'b0, V_FIXMX, 1, 0);
      run_vec(2, "c4 inv fixed", V_FIXMX, 1'b1, V_FIXIN, 1, 0);
      run_vec(1, "c2 fwd fips", V_PLAIN, 1'b0, V_MIXED, 2, 0);
      run_vec(0, "c1 inv toggled", V_MIXED, 1'b1, V_PLAIN, 4, 0);
      run_vec(0, "c1 backpressure", V_PLAIN, 1'b0, V_MIXED, 4, 10);

      // Reset while two columns are done (col_idx = 2).
      in_valid[0] = 1'b1;
      in_state[0] = V_PLAIN;
      in_inv[0]   = 1'b0;
      tick();
      in_valid[0] = 1'b0;
      tick();
      tick();
      reset[0] = 1'b1;
      #1;
      chk_eq("mid reset in_ready while reset high", 128'(in_ready[0]), 128'd0);
      tick();
      reset[0] = 1'b0;
      #1;
      chk_eq("mid reset out_valid", 128'(out_valid[0]), 128'd0);
      chk_eq("mid reset out_state", out_state[0], 128'd0);
      chk_eq("mid reset in_ready", 128'(in_ready[0]), 128'd1);
      run_vec(0, "c1 after reset", V_FIXIN, 1'b0, V_FIXMX, 4, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
